alu_bist_sequencer: RTL and testbench

- Hardware self-test sequencer for the 8-bit ALU (operands A/B, select S, 16-bit result O, flags zero/carry/sign/overflow).
- It drives a fixed table of 40 operand/opcode vectors into the ALU and waits a programmable settle time. It then captures O and the four flags, and compresses them into a 20-bit MISR signature.
- It sits beside the ALU as its on-chip stimulus and response end. Pass/fail is judged against a golden signature.

---
 rtl/alu_bist_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_bist_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_bist_sequencer.sv
// Purpose : BIST sequencer for the 8-bit ALU. It drives 40 fixed operand/opcode vectors,
//           captures the result and flags, and folds them into a 20-bit MISR signature.
// Latency : SETTLE_CYCLES+1 cycles per vector, so done rises 40*(SETTLE_CYCLES+1) edges after start.
// Backpres: none. start is sampled only in IDLE/DONE and ignored while a run is in progress.
// Ports   : clk/reset (sync, active-high) | start | A,B,S -> ALU | O + 4 flags <- ALU
//           busy, done, pass, signature, vector_index status outputs
module alu_bist_sequencer #(
  parameter int          SETTLE_CYCLES = 2,        // legal 1..15
  parameter logic [19:0] EXPECTED_SIG  = 20'h00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [2:0]  S,
  input  logic [15:0] O,
  input  logic        zeroFlag,
  input  logic        carryFlag,
  input  logic        signFlag,
  input  logic        overflowFlag,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [19:0] signature,
  output logic [5:0]  vector_index
);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [5:0] IDX_LAST = 6'd39;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [2:0]  s_q, s_d;
  logic [5:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] sig_q, sig_d;
  logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [19:0] cap_dat, misr_next;
  logic [5:0]  idx_inc;

  // Operand pairs; the table index is pair*8 + opcode.
  function automatic logic [7:0] pair_a(input logic [2:0] p);
    case (p)
      3'd1:       pair_a = 8'd5;
      3'd2, 3'd3: pair_a = 8'd127;
      3'd4:       pair_a = 8'd255;
      default:    pair_a = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] pair_b(input logic [2:0] p);
    case (p)
      3'd1:    pair_b = 8'd7;
      3'd2:    pair_b = 8'd63;
      3'd3:    pair_b = 8'd200;
      3'd4:    pair_b = 8'd255;
      default: pair_b = 8'd0;
    endcase
  endfunction

  assign cap_dat   = {O, zeroFlag, carryFlag, signFlag, overflowFlag};
  // Shift with feedback taps 19 and 16, then fold the captured response in.
  assign misr_next = {sig_q[18:0], sig_q[19] ^ sig_q[16]} ^ cap_dat;
  assign idx_inc   = idx_q + 6'd1;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 6'd0;
          cnt_d   = 4'd0;
          sig_d   = 20'h00000;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          a_d     = pair_a(3'd0);
          b_d     = pair_b(3'd0);
          s_d     = 3'd0;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = CAPTURE;
      end
      CAPTURE: begin
        sig_d = misr_next;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (misr_next == EXPECTED_SIG);
        end else begin
          state_d = DRIVE;
          idx_d   = idx_inc;
          cnt_d   = 4'd0;
          a_d     = pair_a(idx_inc[5:3]);
          b_d     = pair_b(idx_inc[5:3]);
          s_d     = idx_inc[2:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      s_q     <= 3'd0;
      idx_q   <= 6'd0;
      cnt_q   <= 4'd0;
      sig_q   <= 20'h00000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign A            = a_q;
  assign B            = b_q;
  assign S            = s_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign signature    = sig_q;
  assign vector_index = idx_q;

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Directed bench for alu_bist_sequencer with a behavioural ALU stub and a MISR reference model.
module tb_alu_bist_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  A, B;
  logic [2:0]  S;
  logic [15:0] O;
  logic        zeroFlag, carryFlag, signFlag, overflowFlag;
  logic        busy, done, pass;
  logic [19:0] signature;
  logic [5:0]  vector_index;

  bit fold_en  = 1'b0;
  bit fault_en = 1'b0;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_bist_sequencer #(.SETTLE_CYCLES(2), .EXPECTED_SIG(20'h00000)) dut (
    .clk(clk), .reset(reset), .start(start),
    .A(A), .B(B), .S(S), .O(O),
    .zeroFlag(zeroFlag), .carryFlag(carryFlag), .signFlag(signFlag), .overflowFlag(overflowFlag),
    .busy(busy), .done(done), .pass(pass), .signature(signature), .vector_index(vector_index)
  );

  // ALU stub: either all-zero response or O={A,B} with flags taken from S.
  always_comb begin
    O = 16'h0000; zeroFlag = 1'b0; carryFlag = 1'b0; signFlag = 1'b0; overflowFlag = 1'b0;
    if (fold_en) begin
      O = {A, B};
      zeroFlag = S[2]; carryFlag = S[1]; signFlag = S[0]; overflowFlag = S[0];
      if (fault_en && vector_index == 6'd17) O[0] = ~O[0];
    end
  end

  function automatic logic [19:0] model_sig(input bit fold, input bit fault);
    int pa [5] = '{0, 5, 127, 127, 255};
    int pb [5] = '{0, 7, 63, 200, 255};
    logic [19:0] sig = 20'h0;
    logic [19:0] d;
    logic [2:0]  s;
    for (int i = 0; i < 40; i++) begin
      s = 3'(i % 8);
      d = fold ? {8'(pa[i/8]), 8'(pb[i/8]), s[2], s[1], s[0], s[0]} : 20'h0;
      if (fold && fault && i == 17) d[4] = ~d[4];
      sig = {sig[18:0], sig[19] ^ sig[16]} ^ d;
    end
    return sig;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_A"}, 32'(A), 32'h0);
    chk({tag, "_B"}, 32'(B), 32'h0);
    chk({tag, "_S"}, 32'(S), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_pass"}, 32'(pass), 32'h0);
    chk({tag, "_sig"}, 32'(signature), 32'h0);
    chk({tag, "_idx"}, 32'(vector_index), 32'h0);
  endtask

  // Start edge: vector 0 driven, signature cleared, busy up.
  task automatic do_start(input string tag, input bit hold);
    start = 1'b1;
    tick();
    start = hold;
    chk({tag, "_busy"}, 32'(busy), 32'h1);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_idx"}, 32'(vector_index), 32'h0);
    chk({tag, "_sig"}, 32'(signature), 32'h0);
    chk({tag, "_ABS"}, {13'h0, A, B, S}, 32'h0);
  endtask

  // Runs until done (bounded); optionally checks vectors 13/27 and pulses start mid-run.
  task automatic run_to_done(input string tag, input bit chk_vec, input int pulse_at, input bit hold);
    int  edges = 0;
    bit  seen13 = 0, seen27 = 0;
    while (!done && edges < 300) begin
      start = hold || (edges == pulse_at);
      tick();
      edges++;
      if (chk_vec && vector_index == 6'd13 && !seen13) begin
        seen13 = 1;
        chk({tag, "_v13"}, {13'h0, A, B, S}, {13'h0, 8'd5, 8'd7, 3'd5});
      end
      if (chk_vec && vector_index == 6'd27 && !seen27) begin
        seen27 = 1;
        chk({tag, "_v27"}, {13'h0, A, B, S}, {13'h0, 8'd127, 8'd200, 3'd3});
      end
    end
    start = hold;
    chk({tag, "_done_edge"}, 32'(edges), 32'd120);
    chk({tag, "_busy_low"}, 32'(busy), 32'h0);
    if (chk_vec) chk({tag, "_vec_seen"}, {30'h0, seen13, seen27}, 32'h3);
  endtask

  initial begin
    logic [19:0] clean_sig, fault_sig;
    int          guard;
    clean_sig = model_sig(1'b1, 1'b0);
    fault_sig = model_sig(1'b1, 1'b1);
    reset = 1'b1; start = 1'b0;

    // Reset and idle.
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk_all_zero("idle");

    // Zero-response run with timing and vector table checks.
    fold_en = 1'b0;
    do_start("zstart", 1'b0);
    run_to_done("zrun", 1'b1, -1, 1'b0);
    chk("zrun_sig", 32'(signature), 32'h0);
    chk("zrun_pass", 32'(pass), 32'h1);
    chk("zrun_done", 32'(done), 32'h1);

    // Folded-data run with an ignored start pulse mid-run.
    fold_en = 1'b1;
    do_start("fstart", 1'b0);
    run_to_done("frun", 1'b0, 50, 1'b0);
    chk("frun_sig", 32'(signature), 32'(clean_sig));
    chk("frun_pass", 32'(pass), 32'(clean_sig == 20'h0));
    tick(); tick();
    chk("frun_hold_sig", 32'(signature), 32'(clean_sig));
    chk("frun_hold_done", 32'(done), 32'h1);

    // Single-bit fault at vector 17; restart from DONE clears the signature.
    fault_en = 1'b1;
    do_start("xstart", 1'b0);
    run_to_done("xrun", 1'b0, -1, 1'b0);
    chk("xrun_sig", 32'(signature), 32'(fault_sig));
    chk("xrun_pass", 32'(pass), 32'h0);
    checks++;
    assert (signature !== clean_sig) else begin
      failures++;
      $error("FAIL xrun_differs observed=%0h expected!=%0h", signature, clean_sig);
    end
    fault_en = 1'b0;

    // start held high: back-to-back runs with a one-cycle DONE.
    do_start("hstart", 1'b1);
    run_to_done("hrun", 1'b0, -1, 1'b1);
    chk("hrun_sig", 32'(signature), 32'(clean_sig));
    tick();
    chk("hrun_rebusy", 32'(busy), 32'h1);
    chk("hrun_redone", 32'(done), 32'h0);
    chk("hrun_resig", 32'(signature), 32'h0);
    chk("hrun_reidx", 32'(vector_index), 32'h0);
    run_to_done("hrun2", 1'b0, -1, 1'b0);
    chk("hrun2_sig", 32'(signature), 32'(clean_sig));

    // Reset in the middle of a run, then a clean rerun.
    do_start("rstart", 1'b0);
    guard = 0;
    while (vector_index != 6'd20 && guard < 200) begin tick(); guard++; end
    chk("rst_reach20", 32'(vector_index), 32'd20);
    reset = 1'b1;
    tick();
    chk_all_zero("midrst");
    reset = 1'b0;
    tick();
    do_start("r2start", 1'b0);
    run_to_done("r2run", 1'b0, -1, 1'b0);
    chk("r2run_sig", 32'(signature), 32'(clean_sig));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
